// File: rtl/fft256_ctrl_pkg.sv
// Shared constants, types and helpers for the 256-point radix-2 DIF FFT
// sequencing controller.
//   - LOG2N / N / NB : transform size and butterflies per stage
//   - state_t + ST_* : controller states
//   - wb_t           : write-back payload carried through the butterfly delay line
//   - bitrev / span_of / tw_of : address and twiddle helpers
package fft256_ctrl_pkg;

  localparam int unsigned LOG2N = 8;
  localparam int unsigned N     = 1 << LOG2N;
  localparam int unsigned NB    = N / 2;
  localparam int unsigned STG_W = $clog2(LOG2N);

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_LOAD    = 2'd1;
  localparam state_t ST_COMPUTE = 2'd2;
  localparam state_t ST_UNLOAD  = 2'd3;

  typedef struct packed {
    logic             vld;
    logic [LOG2N-1:0] addr_a;
    logic [LOG2N-1:0] addr_b;
  } wb_t;

  // Bit-reverse an address (natural-order output from a DIF in-place transform).
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < int'(LOG2N); i++) r[i] = x[LOG2N-1-i];
    return r;
  endfunction

  // Distance between the two butterfly operands in stage s: N >> (s+1).
  function automatic logic [LOG2N-1:0] span_of(input logic [STG_W-1:0] s);
    return LOG2N'(N >> (s + 1));
  endfunction

  // Twiddle ROM index: position within the group scaled by 2^s.
  function automatic logic [LOG2N-2:0] tw_of(input logic [LOG2N-1:0] pos,
                                             input logic [STG_W-1:0] s);
    return (LOG2N-1)'(pos << s);
  endfunction

endpackage

// File: rtl/fft256_bfly_addr_gen.sv
// Combinational butterfly address generator.
//   i_stage      : compute stage s (0..LOG2N-1)
//   i_bfly       : butterfly index b within the stage (0..N/2-1)
//   o_addr_a_c   : 2*grp*span + pos
//   o_addr_b_c   : o_addr_a_c + span
//   o_tw_idx_c   : pos << s
module fft256_bfly_addr_gen
  import fft256_ctrl_pkg::*;
(
  input  logic [STG_W-1:0] i_stage,
  input  logic [LOG2N-2:0] i_bfly,
  output logic [LOG2N-1:0] o_addr_a_c,
  output logic [LOG2N-1:0] o_addr_b_c,
  output logic [LOG2N-2:0] o_tw_idx_c
);

  logic [LOG2N-1:0] w_span;
  logic [LOG2N-1:0] w_mask;
  logic [LOG2N-1:0] w_b;
  logic [LOG2N-1:0] w_pos;

  // span is a power of two, so grp/pos split is a mask; addr_a inserts a 0 at the span bit
  always_comb begin
    w_span     = span_of(i_stage);
    w_mask     = w_span - 1'b1;
    w_b        = {1'b0, i_bfly};
    w_pos      = w_b & w_mask;
    o_addr_a_c = ((w_b & ~w_mask) << 1) | w_pos;
    o_addr_b_c = o_addr_a_c | w_span;
    o_tw_idx_c = tw_of(w_pos, i_stage);
  end

endmodule

// File: rtl/fft256_seq_ctrl.sv
// Sequencing controller for the 256-point in-place radix-2 DIF FFT core
// (one butterfly unit, one dual-port sample RAM).
// Optional feature macro: FFT_SCALE_SCHED_EN (adds scale_mask, per-stage scaling).
// Ports:
//   clk, rst (sync, active-high), in_valid
//   load_we/load_addr                     : input sample write, natural order
//   bf_issue/bf_rd_addr_a/b/tw_idx/bf_scale : butterfly operand issue
//   bf_wr_en/bf_wr_addr_a/b               : butterfly write-back (issue + BFLY_LAT)
//   unload_re/unload_addr                 : bit-reversed result read
//   out_valid                             : unload_re + RD_LAT, 256 cycles per frame
//   busy, stage, err_ovr                  : status
//   scale_mask                            : per-stage scale enable (FFT_SCALE_SCHED_EN only)
module fft256_seq_ctrl
  import fft256_ctrl_pkg::*;
#(
  parameter int unsigned BFLY_LAT = 3,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
`ifdef FFT_SCALE_SCHED_EN
  input  logic [LOG2N-1:0] scale_mask,
`endif
  output logic             load_we,
  output logic [LOG2N-1:0] load_addr,
  output logic             bf_issue,
  output logic [LOG2N-1:0] bf_rd_addr_a,
  output logic [LOG2N-1:0] bf_rd_addr_b,
  output logic [LOG2N-2:0] tw_idx,
  output logic             bf_scale,
  output logic             bf_wr_en,
  output logic [LOG2N-1:0] bf_wr_addr_a,
  output logic [LOG2N-1:0] bf_wr_addr_b,
  output logic             unload_re,
  output logic [LOG2N-1:0] unload_addr,
  output logic             out_valid,
  output logic             busy,
  output logic [STG_W-1:0] stage,
  output logic             err_ovr
);

  localparam int unsigned CYC_W = $clog2(NB + BFLY_LAT);
  localparam int unsigned K_W   = $clog2(N + RD_LAT);
  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(NB + BFLY_LAT - 1);
  localparam logic [CYC_W-1:0] CYC_ISSUE = CYC_W'(NB);
  localparam logic [K_W-1:0]   K_LAST    = K_W'(N + RD_LAT - 1);
  localparam logic [K_W-1:0]   K_RE      = K_W'(N);
  localparam logic [LOG2N-1:0] CNT_LAST  = LOG2N'(N - 1);
  localparam logic [STG_W-1:0] STG_LAST  = STG_W'(LOG2N - 1);

  state_t           r_state, w_state_nxt;
  logic [LOG2N-1:0] r_cnt, w_cnt_nxt;
  logic [CYC_W-1:0] r_cyc, w_cyc_nxt;
  logic [STG_W-1:0] r_stg, w_stg_nxt;
  logic [K_W-1:0]   r_k, w_k_nxt;

  logic             w_load_we, w_err, w_issue, w_unload_re, w_scale;
  logic [LOG2N-1:0] w_rd_a, w_rd_b;
  logic [LOG2N-2:0] w_tw;

  logic             r_load_we, r_bf_issue, r_bf_scale, r_unload_re, r_busy, r_err;
  logic [LOG2N-1:0] r_load_addr, r_rd_a, r_rd_b, r_unload_addr;
  logic [LOG2N-2:0] r_tw;
  logic [STG_W-1:0] r_stage;
  wb_t              r_wb_dly [BFLY_LAT];
  logic             r_ov_dly [RD_LAT];

`ifdef FFT_SCALE_SCHED_EN
  logic             r_scale_hold;
`endif

  // State and counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_cyc   <= '0;
      r_stg   <= '0;
      r_k     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cyc   <= w_cyc_nxt;
      r_stg   <= w_stg_nxt;
      r_k     <= w_k_nxt;
    end
  end

  // Next state; counters describe the cycle they are registered into
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cyc_nxt   = r_cyc;
    w_stg_nxt   = r_stg;
    w_k_nxt     = r_k;
    w_load_we   = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      ST_IDLE, ST_LOAD: begin
        if (in_valid) begin
          w_load_we = 1'b1;
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = ST_COMPUTE;
            w_cnt_nxt   = '0;
            w_cyc_nxt   = '0;
            w_stg_nxt   = '0;
          end else begin
            w_state_nxt = ST_LOAD;
            w_cnt_nxt   = r_cnt + 1'b1;
          end
        end
      end
      ST_COMPUTE: begin
        w_err = in_valid;
        // each stage = NB issue cycles + BFLY_LAT drain cycles (write-back before next read)
        if (r_cyc == CYC_LAST) begin
          w_cyc_nxt = '0;
          if (r_stg == STG_LAST) begin
            w_state_nxt = ST_UNLOAD;
            w_stg_nxt   = '0;
            w_k_nxt     = '0;
          end else begin
            w_stg_nxt = r_stg + 1'b1;
          end
        end else begin
          w_cyc_nxt = r_cyc + 1'b1;
        end
      end
      ST_UNLOAD: begin
        // tail of RD_LAT cycles keeps the frame open until the last out_valid
        if (r_k == K_LAST) begin
          w_k_nxt = '0;
          if (in_valid) begin
            w_load_we   = 1'b1;
            w_cnt_nxt   = LOG2N'(1);
            w_state_nxt = ST_LOAD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_k_nxt = r_k + 1'b1;
          w_err   = in_valid;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_issue     = (w_state_nxt == ST_COMPUTE) && (w_cyc_nxt < CYC_ISSUE);
    w_unload_re = (w_state_nxt == ST_UNLOAD) && (w_k_nxt < K_RE);
`ifdef FFT_SCALE_SCHED_EN
    w_scale = (w_cyc_nxt == '0) ? scale_mask[w_stg_nxt] : r_scale_hold;
`else
    w_scale = 1'b1;
`endif
  end

  fft256_bfly_addr_gen u_addr_gen (
    .i_stage    (w_stg_nxt),
    .i_bfly     ((LOG2N-1)'(w_cyc_nxt)),
    .o_addr_a_c (w_rd_a),
    .o_addr_b_c (w_rd_b),
    .o_tw_idx_c (w_tw)
  );

  // Registered outputs and write-back / out_valid delay lines
  always_ff @(posedge clk) begin
    if (rst) begin
      r_load_we     <= 1'b0;
      r_load_addr   <= '0;
      r_bf_issue    <= 1'b0;
      r_rd_a        <= '0;
      r_rd_b        <= '0;
      r_tw          <= '0;
      r_bf_scale    <= 1'b0;
      r_unload_re   <= 1'b0;
      r_unload_addr <= '0;
      r_busy        <= 1'b0;
      r_stage       <= '0;
      r_err         <= 1'b0;
      for (int i = 0; i < int'(BFLY_LAT); i++) r_wb_dly[i] <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) r_ov_dly[i] <= 1'b0;
    end else begin
      r_load_we     <= w_load_we;
      r_load_addr   <= r_cnt;
      r_bf_issue    <= w_issue;
      r_rd_a        <= w_rd_a;
      r_rd_b        <= w_rd_b;
      r_tw          <= w_tw;
      r_bf_scale    <= w_issue & w_scale;
      r_unload_re   <= w_unload_re;
      r_unload_addr <= bitrev(LOG2N'(w_k_nxt));
      r_busy        <= (w_state_nxt != ST_IDLE);
      r_stage       <= w_stg_nxt;
      r_err         <= w_err;
      r_wb_dly[0]   <= '{vld: r_bf_issue, addr_a: r_rd_a, addr_b: r_rd_b};
      for (int i = 1; i < int'(BFLY_LAT); i++) r_wb_dly[i] <= r_wb_dly[i-1];
      r_ov_dly[0]   <= r_unload_re;
      for (int i = 1; i < int'(RD_LAT); i++) r_ov_dly[i] <= r_ov_dly[i-1];
    end
  end

`ifdef FFT_SCALE_SCHED_EN
  // Stage scale bit captured on the first issue and held for the stage
  always_ff @(posedge clk) begin
    if (rst) r_scale_hold <= 1'b0;
    else if (w_issue) r_scale_hold <= w_scale;
  end
`endif

  assign load_we      = r_load_we;
  assign load_addr    = r_load_addr;
  assign bf_issue     = r_bf_issue;
  assign bf_rd_addr_a = r_rd_a;
  assign bf_rd_addr_b = r_rd_b;
  assign tw_idx       = r_tw;
  assign bf_scale     = r_bf_scale;
  assign bf_wr_en     = r_wb_dly[BFLY_LAT-1].vld;
  assign bf_wr_addr_a = r_wb_dly[BFLY_LAT-1].addr_a;
  assign bf_wr_addr_b = r_wb_dly[BFLY_LAT-1].addr_b;
  assign unload_re    = r_unload_re;
  assign unload_addr  = r_unload_addr;
  assign out_valid    = r_ov_dly[RD_LAT-1];
  assign busy         = r_busy;
  assign stage        = r_stage;
  assign err_ovr      = r_err;

endmodule

// File: tb/tb_fft256_seq_ctrl.sv
// Directed self-checking bench for fft256_seq_ctrl (default BFLY_LAT=3, RD_LAT=1).
module tb_fft256_seq_ctrl;

  localparam int LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
`ifdef FFT_SCALE_SCHED_EN
  logic [7:0] scale_mask = 8'b1010_0101;
`endif
  logic       load_we, bf_issue, bf_scale, bf_wr_en, unload_re, out_valid, busy, err_ovr;
  logic [7:0] load_addr, bf_rd_addr_a, bf_rd_addr_b, bf_wr_addr_a, bf_wr_addr_b, unload_addr;
  logic [6:0] tw_idx;
  logic [2:0] stage;

  fft256_seq_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
`ifdef FFT_SCALE_SCHED_EN
    .scale_mask   (scale_mask),
`endif
    .load_we      (load_we),
    .load_addr    (load_addr),
    .bf_issue     (bf_issue),
    .bf_rd_addr_a (bf_rd_addr_a),
    .bf_rd_addr_b (bf_rd_addr_b),
    .tw_idx       (tw_idx),
    .bf_scale     (bf_scale),
    .bf_wr_en     (bf_wr_en),
    .bf_wr_addr_a (bf_wr_addr_a),
    .bf_wr_addr_b (bf_wr_addr_b),
    .unload_re    (unload_re),
    .unload_addr  (unload_addr),
    .out_valid    (out_valid),
    .busy         (busy),
    .stage        (stage),
    .err_ovr      (err_ovr)
  );

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_tot++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] brev(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  function automatic logic exp_scale(input int s);
`ifdef FFT_SCALE_SCHED_EN
    logic [7:0] m;
    m = 8'b1010_0101;
    return m[s];
`else
    return (s >= 0);
`endif
  endfunction

  // Monitor state
  int cyc = 0;
  int n_load = 0, load_bad = 0, err_cnt = 0, wr_bad = 0, scale_bad = 0;
  int n_iss = 0, idx = 0, iss_first = 0, iss128 = 0;
  int a5 = 0, b5 = 0, tw5 = 0, st5 = 0, a901 = 0, b901 = 0, tw901 = 0, st901 = 0;
  int n_unl = 0, k = 0, unl_bad = 0, unl_start = 0, unl_k1 = 0;
  int ov_start = 0, ov_len = 0;
  logic prev_ov = 1'b0;
  logic       h_v [LAT];
  logic [7:0] h_a [LAT];
  logic [7:0] h_b [LAT];

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      n_iss = 0;
      n_unl = 0;
      for (int i = 0; i < LAT; i++) begin h_v[i] = 1'b0; h_a[i] = '0; h_b[i] = '0; end
    end else begin
      if (load_we) begin
        if (int'(load_addr) != n_load % 256) load_bad++;
        n_load++;
      end
      if (err_ovr) err_cnt++;
      if (bf_wr_en != h_v[LAT-1] ||
          (bf_wr_en && (bf_wr_addr_a != h_a[LAT-1] || bf_wr_addr_b != h_b[LAT-1]))) wr_bad++;
      for (int i = LAT - 1; i > 0; i--) begin
        h_v[i] = h_v[i-1]; h_a[i] = h_a[i-1]; h_b[i] = h_b[i-1];
      end
      h_v[0] = bf_issue; h_a[0] = bf_rd_addr_a; h_b[0] = bf_rd_addr_b;
      if (bf_issue) begin
        idx = n_iss % 1024;
        if (idx == 0) iss_first = cyc;
        if (idx == 128) iss128 = cyc;
        if (idx == 5) begin a5 = bf_rd_addr_a; b5 = bf_rd_addr_b; tw5 = tw_idx; st5 = stage; end
        if (idx == 901) begin a901 = bf_rd_addr_a; b901 = bf_rd_addr_b; tw901 = tw_idx; st901 = stage; end
        if (bf_scale != exp_scale(idx / 128)) scale_bad++;
        n_iss++;
      end
      if (unload_re) begin
        k = n_unl % 256;
        if (k == 0) unl_start = cyc;
        if (k == 1) unl_k1 = unload_addr;
        if (unload_addr != brev(8'(k))) unl_bad++;
        n_unl++;
      end
      if (out_valid && !prev_ov) ov_start = cyc;
      if (!out_valid && prev_ov) ov_len = cyc - ov_start;
      prev_ov = out_valid;
    end
  end

  task automatic drive_frame(input int gap_after, input int gap_len,
                             output int t_first, output int t_last);
    t_first = 0;
    t_last  = 0;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      if (i == 0) t_first = cyc;
      t_last = cyc;
      if (i == gap_after) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (gap_len - 1) @(posedge clk);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 3000) begin @(negedge clk); n++; end
    chk_eq(tag, busy, 0);
    repeat (2) @(negedge clk);
  endtask

  int tf, tl, tf_e, tl_e, tf_f, tl_f, quiet, n;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_load_we", load_we, 0);
    chk_eq("rst_issue", bf_issue, 0);
    chk_eq("rst_wr_en", bf_wr_en, 0);
    chk_eq("rst_unload_re", unload_re, 0);
    chk_eq("rst_out_valid", out_valid, 0);
    chk_eq("rst_err", err_ovr, 0);
    chk_eq("rst_stage", stage, 0);

    // Frame A: contiguous input
    drive_frame(-1, 0, tf, tl);
    wait_idle("a_idle");
    chk_eq("a_loads", n_load, 256);
    chk_eq("a_first_issue", iss_first - tl, 1);
    chk_eq("a_stage_len", iss128 - iss_first, 131);
    chk_eq("a_s0b5_a", a5, 5);
    chk_eq("a_s0b5_b", b5, 133);
    chk_eq("a_s0b5_tw", tw5, 5);
    chk_eq("a_s0b5_stage", st5, 0);
    chk_eq("a_s7b5_a", a901, 10);
    chk_eq("a_s7b5_b", b901, 11);
    chk_eq("a_s7b5_tw", tw901, 0);
    chk_eq("a_s7b5_stage", st901, 7);
    chk_eq("a_unload_start", unl_start - tl, 1049);
    chk_eq("a_ov_start", ov_start - tl, 1050);
    chk_eq("a_ov_len", ov_len, 256);

    // Frame B: 10-cycle gap after sample 100
    drive_frame(100, 10, tf, tl);
    wait_idle("b_idle");
    chk_eq("b_load_seq", load_bad, 0);
    chk_eq("b_loads", n_load, 512);
    chk_eq("b_ov_from_first", ov_start - tf, 1315);
    chk_eq("b_ov_len", ov_len, 256);

    // Frame C: stray in_valid during COMPUTE
    drive_frame(-1, 0, tf, tl);
    repeat (40) @(posedge clk);
    #1 in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk_eq("c_err_pulse", err_ovr, 1);
    chk_eq("c_no_load", load_we, 0);
    @(negedge clk);
    chk_eq("c_err_one_cycle", err_ovr, 0);
    wait_idle("c_idle");
    chk_eq("c_err_cnt", err_cnt, 1);
    chk_eq("c_loads", n_load, 768);
    chk_eq("c_unl_k1", unl_k1, 128);
    chk_eq("c_ov_start", ov_start - tl, 1050);
    chk_eq("c_ov_len", ov_len, 256);

    // Frame D: reset during stage 3
    drive_frame(-1, 0, tf, tl);
    n = 0;
    while (stage != 3'd3 && n < 2000) begin @(negedge clk); n++; end
    chk_eq("d_reach_stage3", stage, 3);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_eq("d_busy", busy, 0);
    chk_eq("d_wr_en", bf_wr_en, 0);
    chk_eq("d_issue", bf_issue, 0);
    chk_eq("d_stage", stage, 0);
    chk_eq("d_scale", bf_scale, 0);
    quiet = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bf_wr_en || busy || bf_issue || unload_re || out_valid) quiet++;
    end
    chk_eq("d_quiet", quiet, 0);

    // Frame E, then frame F starting in the cycle of E's final out_valid
    drive_frame(-1, 0, tf_e, tl_e);
    repeat (1303) @(posedge clk);
    fork
      drive_frame(-1, 0, tf_f, tl_f);
      begin
        @(posedge clk);
        @(negedge clk);
        chk_eq("f_overlap_ov", out_valid, 1);
        @(negedge clk);
        chk_eq("f_first_we", load_we, 1);
        chk_eq("f_first_addr", load_addr, 0);
        chk_eq("f_no_err", err_ovr, 0);
        chk_eq("f_ov_done", out_valid, 0);
        repeat (2) @(negedge clk);
        chk_eq("e_ov_start", ov_start - tl_e, 1050);
        chk_eq("e_ov_len", ov_len, 256);
      end
    join
    chk_eq("f_overlap_cycle", tf_f - tl_e, 1305);
    wait_idle("f_idle");
    chk_eq("f_ov_start", ov_start - tl_f, 1050);
    chk_eq("f_ov_len", ov_len, 256);
    chk_eq("all_loads", n_load, 1536);
    chk_eq("all_load_seq", load_bad, 0);
    chk_eq("all_err_cnt", err_cnt, 1);
    chk_eq("all_wr_mirror", wr_bad, 0);
    chk_eq("all_scale", scale_bad, 0);
    chk_eq("all_unload_seq", unl_bad, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/fft256_seq_ctrl.md
Name: fft256_seq_ctrl

Overview:
Sequencing controller for the 256-point in-place radix-2 DIF FFT core, which has one butterfly unit and one dual-port sample RAM.
- Accepts the 256-sample input stream and generates RAM write addresses.
- Schedules 8 butterfly stages: read/write addresses, twiddle index and per-stage scaling.
- Unloads results in natural frequency order by reading bit-reversed addresses.
- Drives the top-level out_valid for exactly 256 consecutive cycles per frame.

Parameters:
- LOG2N, 8, log2 of FFT length; N = 2^LOG2N.
- BFLY_LAT, 3, butterfly pipeline latency, read-issue to write-back, in cycles (≥1).
- RD_LAT, 1, RAM read latency, address to data, in cycles.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input sample valid; one sample per cycle.
- load_we  out  1  RAM write enable for the input sample.
- load_addr  out  LOG2N  RAM write address, natural order.
- bf_issue  out  1  butterfly operand read issued this cycle.
- bf_rd_addr_a / bf_rd_addr_b  out  LOG2N each  operand read addresses.
- tw_idx  out  LOG2N-1  twiddle ROM index.
- bf_scale  out  1  butterfly applies >>1 on this issue.
- bf_wr_en  out  1  butterfly result write-back enable.
- bf_wr_addr_a / bf_wr_addr_b  out  LOG2N each  write-back addresses.
- unload_re  out  1  RAM read enable for output.
- unload_addr  out  LOG2N  bit-reversed read address.
- out_valid  out  1  output sample valid (top-level handshake).
- busy  out  1  high in every state except IDLE.
- stage  out  3  current compute stage, 0..LOG2N-1.
- err_ovr  out  1  one-cycle pulse when in_valid arrives outside IDLE/LOAD.
- scale_mask  in  LOG2N  per-stage scale enable; present only under FFT_SCALE_SCHED_EN.

Behaviour:
- Reset: all outputs 0; state IDLE; all counters 0; write-back delay line cleared. A reset mid-frame aborts the frame, and no bf_wr_en is asserted after the cycle in which rst is sampled.
- States: IDLE -> LOAD -> COMPUTE -> UNLOAD -> IDLE.
- IDLE/LOAD:
  - Each in_valid cycle: load_we=1, load_addr=sample count, count increments.
  - in_valid low mid-load: count holds; no timeout.
  - On the 256th sample: go to COMPUTE on the next cycle.
- COMPUTE, stage s = 0..LOG2N-1, butterfly b = 0..N/2-1, one issue per cycle:
  - span = N>>(s+1); grp = b/span; pos = b%span.
  - addr_a = 2*grp*span + pos; addr_b = addr_a + span.
  - tw_idx = pos<<s.
  - bf_scale = 1 (default build).
  - bf_wr_en and write addresses are bf_issue and read addresses delayed exactly BFLY_LAT cycles via a shift register.
- Stage drain: after the last issue of stage s, wait BFLY_LAT cycles so write-back completes (RAW hazard), then begin stage s+1. Each stage therefore lasts N/2+BFLY_LAT cycles. stage updates on the first issue cycle of the new stage.
- UNLOAD:
  - k = 0..N-1 on consecutive cycles; unload_re=1, unload_addr = bitrev(k).
  - out_valid = unload_re delayed RD_LAT cycles.
  - Returns to IDLE once the last out_valid has been driven; out_valid is never high for more or fewer than 256 consecutive cycles.
- Latency: last input sample in cycle T.
  - First bf_issue at T+1.
  - First unload_re at T+1+LOG2N*(N/2+BFLY_LAT); default T+1049.
  - First out_valid at RD_LAT later; default T+1050.
- in_valid during COMPUTE/UNLOAD: ignored (no RAM write), err_ovr pulses for each such cycle.
- in_valid in the same cycle as the final out_valid: counts as the first sample of a new frame; LOAD starts that cycle.

Optional Feature:
- Macro: FFT_SCALE_SCHED_EN.
- Defined: scale_mask port exists; bf_scale = scale_mask[stage], sampled at the first issue of each stage and held for that stage.
- Undefined: no scale_mask port; bf_scale = 1 on every issue (total /256).

Decomposition:
- Package fft256_ctrl_pkg: state enum, N/LOG2N constants, bitrev function, span/twiddle helper functions.
- One sub-module, fft256_bfly_addr_gen: combinational s,b -> addr_a, addr_b, tw_idx.
- Delay lines and FSM stay in the top module.

Test Plan:
- 256 contiguous in_valid cycles -> load_addr 0..255; first bf_issue at T+1; out_valid high exactly 256 cycles starting T+1050 (defaults).
- Stage 0, b=5 -> addr_a=5, addr_b=133, tw_idx=5. Stage 7, b=5 -> addr_a=10, addr_b=11, tw_idx=0. bf_wr_en mirrors bf_issue 3 cycles later.
- in_valid gap of 10 cycles after sample 100 -> count holds at 101; the frame completes normally; out_valid shifts late by 10 cycles.
- in_valid pulsed during COMPUTE -> err_ovr pulses, no load_we; the UNLOAD sequence is unchanged (unload_addr for k=1 is 128).
- rst asserted at stage 3 -> next cycle: busy=0, bf_wr_en=0, all outputs 0; a new 256-sample frame then completes correctly.
- FFT_SCALE_SCHED_EN with scale_mask=8'b1010_0101 -> bf_scale high only during stages 0, 2, 5, 7.
